// File: rtl/rv32i_instr_mem_banked.sv
// rv32i_instr_mem_banked: DATA_W-bit instruction memory built from a narrower BRAM_W-bit synchronous RAM.
// Each word is accessed as BEATS consecutive BRAM beats, with write-over-read arbitration and address checking.
module rv32i_instr_mem_banked #(
    parameter int DATA_W      = 32,
    parameter int BRAM_W      = 16,
    parameter int DEPTH_WORDS = 128,
    parameter int ADDR_W      = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rd_valid,
    output logic              o_rd_ready,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_rsp_valid,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_err,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_done,
    output logic              o_wr_err
);
    localparam int BEATS = DATA_W / BRAM_W;
    localparam int OFFS  = $clog2(DATA_W / 8);
    localparam int WI_W  = $clog2(DEPTH_WORDS);
    localparam int LB    = $clog2(BEATS);
    localparam int BB_W  = BEATS > 1 ? LB : 1;
    localparam int BA_W  = WI_W + LB;

    typedef enum logic [1:0] {IDLE, RD, WR, ERR} state_t;

    state_t              state_q;
    logic [BB_W-1:0]     beat_q;
    logic [WI_W-1:0]     widx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BRAM_W-1:0]   bram_q;
    logic [DATA_W-1:0]   hold_q;
    logic                rsp_q, rerr_q, done_q, werr_q;
    logic [BRAM_W-1:0]   mem [DEPTH_WORDS*BEATS];

    logic              idle, wr_acc, rd_acc, rd_bad, wr_bad, last, re, we;
    logic [WI_W-1:0]   r_idx, w_idx;
    logic [BA_W-1:0]   baddr;
    logic [BRAM_W-1:0] wbeat;
    logic [DATA_W-1:0] word;

    assign idle   = state_q == IDLE;
    assign wr_acc = idle && i_wr_valid && !i_rst;
    assign rd_acc = idle && i_rd_valid && !i_wr_valid && !i_rst;
    assign r_idx  = i_rd_addr[OFFS +: WI_W];
    assign w_idx  = i_wr_addr[OFFS +: WI_W];
    assign rd_bad = (i_rd_addr[OFFS-1:0] != '0) || (i_rd_addr[ADDR_W-1:OFFS] >= (ADDR_W-OFFS)'(DEPTH_WORDS));
    assign wr_bad = (i_wr_addr[OFFS-1:0] != '0) || (i_wr_addr[ADDR_W-1:OFFS] >= (ADDR_W-OFFS)'(DEPTH_WORDS));
    assign last   = beat_q == BB_W'(BEATS - 1);
    // Beat 0 is addressed straight from the request so it issues on the acceptance edge.
    assign baddr  = idle ? (BA_W'(wr_acc ? w_idx : r_idx) << LB)
                         : ((BA_W'(widx_q) << LB) | (BA_W'(beat_q) & BA_W'(BEATS - 1)));
    assign wbeat  = idle ? i_wr_data[BRAM_W-1:0] : wdata_q[BRAM_W-1:0];
    assign re     = (rd_acc && !rd_bad) || state_q == RD;
    assign we     = !i_rst && ((wr_acc && !wr_bad) || state_q == WR);

    assign o_rd_ready     = idle && !i_rst && !i_wr_valid;
    assign o_wr_ready     = idle && !i_rst;
    assign o_rd_rsp_valid = rsp_q;
    assign o_rd_err       = rerr_q;
    assign o_wr_done      = done_q;
    assign o_wr_err       = werr_q;
    assign o_rd_data      = rsp_q ? word : hold_q;

    // Last beat is taken live from the BRAM output register; earlier beats shift into lo_q.
    generate
        if (BEATS > 1) begin : g_lo
            logic [DATA_W-BRAM_W-1:0] lo_q;
            always_ff @(posedge i_clk) begin
                if (i_rst || (rd_acc && rd_bad)) lo_q <= '0;
                else if (state_q == RD) lo_q <= (DATA_W-BRAM_W)'({bram_q, lo_q} >> BRAM_W);
            end
            assign word = {bram_q, lo_q};
        end else begin : g_one
            assign word = bram_q;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (we) mem[baddr] <= wbeat;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            widx_q  <= '0;
            wdata_q <= '0;
            bram_q  <= '0;
            hold_q  <= '0;
            rsp_q   <= 1'b0;
            rerr_q  <= 1'b0;
            done_q  <= 1'b0;
            werr_q  <= 1'b0;
        end else begin
            rsp_q  <= 1'b0;
            done_q <= 1'b0;
            if (rsp_q) hold_q <= word;
            if (re) bram_q <= mem[baddr];
            case (state_q)
                IDLE: begin
                    beat_q <= BB_W'(1);
                    if (wr_acc) begin
                        widx_q  <= w_idx;
                        wdata_q <= i_wr_data >> BRAM_W;
                        state_q <= wr_bad ? ERR : (BEATS > 1 ? WR : IDLE);
                        if (wr_bad || BEATS == 1) begin
                            done_q <= 1'b1;
                            werr_q <= wr_bad;
                        end
                    end else if (rd_acc) begin
                        widx_q  <= r_idx;
                        state_q <= rd_bad ? ERR : (BEATS > 1 ? RD : IDLE);
                        if (rd_bad) bram_q <= '0;
                        if (rd_bad || BEATS == 1) begin
                            rsp_q  <= 1'b1;
                            rerr_q <= rd_bad;
                        end
                    end
                end
                RD: begin
                    beat_q <= beat_q + BB_W'(1);
                    if (last) begin
                        state_q <= IDLE;
                        rsp_q   <= 1'b1;
                        rerr_q  <= 1'b0;
                    end
                end
                WR: begin
                    beat_q  <= beat_q + BB_W'(1);
                    wdata_q <= wdata_q >> BRAM_W;
                    if (last) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        werr_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32i_instr_mem_banked.sv
// tb_rv32i_instr_mem_banked: cycle-accurate vector table for the default 32/16 memory,
// plus hand-written sequences for reset abort, a 64/16 (4-beat) and a 32/32 (1-beat) instance.
module tb_rv32i_instr_mem_banked;
    logic        clk = 1'b0;
    logic        rst;
    logic        rv, wv;
    logic [31:0] ra, wa;
    logic [63:0] wd;
    int          total = 0;
    int          bad = 0;

    logic a_rr, a_wr, a_rsp, a_re, a_dn, a_we;
    logic [31:0] a_d;
    logic b_rr, b_wr, b_rsp, b_re, b_dn, b_we;
    logic [63:0] b_d;
    logic c_rr, c_wr, c_rsp, c_re, c_dn, c_we;
    logic [31:0] c_d;

    always #5 clk = ~clk;

    rv32i_instr_mem_banked u_a (
        .i_clk(clk), .i_rst(rst),
        .i_rd_valid(rv), .o_rd_ready(a_rr), .i_rd_addr(ra),
        .o_rd_rsp_valid(a_rsp), .o_rd_data(a_d), .o_rd_err(a_re),
        .i_wr_valid(wv), .o_wr_ready(a_wr), .i_wr_addr(wa), .i_wr_data(wd[31:0]),
        .o_wr_done(a_dn), .o_wr_err(a_we)
    );

    rv32i_instr_mem_banked #(.DATA_W(64), .BRAM_W(16)) u_b (
        .i_clk(clk), .i_rst(rst),
        .i_rd_valid(rv), .o_rd_ready(b_rr), .i_rd_addr(ra),
        .o_rd_rsp_valid(b_rsp), .o_rd_data(b_d), .o_rd_err(b_re),
        .i_wr_valid(wv), .o_wr_ready(b_wr), .i_wr_addr(wa), .i_wr_data(wd),
        .o_wr_done(b_dn), .o_wr_err(b_we)
    );

    rv32i_instr_mem_banked #(.DATA_W(32), .BRAM_W(32)) u_c (
        .i_clk(clk), .i_rst(rst),
        .i_rd_valid(rv), .o_rd_ready(c_rr), .i_rd_addr(ra),
        .o_rd_rsp_valid(c_rsp), .o_rd_data(c_d), .o_rd_err(c_re),
        .i_wr_valid(wv), .o_wr_ready(c_wr), .i_wr_addr(wa), .i_wr_data(wd[31:0]),
        .o_wr_done(c_dn), .o_wr_err(c_we)
    );

    typedef struct {
        logic        rv;
        logic [31:0] ra;
        logic        wv;
        logic [31:0] wa;
        logic [31:0] wd;
        logic        rr, wr, rsp;
        logic [31:0] d;
        logic        re, dn, we;
    } vec_t;

    vec_t tv[26];

    function automatic vec_t v(logic r, logic [31:0] ra_, logic w, logic [31:0] wa_, logic [31:0] wd_,
                               logic rr, logic wr, logic rsp, logic [31:0] d, logic re, logic dn, logic we);
        v = '{r, ra_, w, wa_, wd_, rr, wr, rsp, d, re, dn, we};
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] ra_, input logic w, input logic [31:0] wa_, input logic [63:0] wd_);
        rv = r; ra = ra_; wv = w; wa = wa_; wd = wd_;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0]  = v(0, 32'h0,  1, 32'h0,   32'h11112222, 0, 1, 0, 32'h0,        0, 0, 0);
        tv[1]  = v(0, 32'h0,  1, 32'h8,   32'h33334444, 0, 0, 0, 32'h0,        0, 0, 0);
        tv[2]  = v(0, 32'h0,  1, 32'h8,   32'h33334444, 0, 1, 0, 32'h0,        0, 1, 0);
        tv[3]  = v(0, 32'h0,  1, 32'h10,  32'hDEADBEEF, 0, 0, 0, 32'h0,        0, 0, 0);
        tv[4]  = v(0, 32'h0,  1, 32'h10,  32'hDEADBEEF, 0, 1, 0, 32'h0,        0, 1, 0);
        tv[5]  = v(1, 32'h10, 0, 32'h0,   32'h0,        0, 0, 0, 32'h0,        0, 0, 0);
        tv[6]  = v(1, 32'h10, 0, 32'h0,   32'h0,        1, 1, 0, 32'h0,        0, 1, 0);
        tv[7]  = v(0, 32'h0,  0, 32'h0,   32'h0,        0, 0, 0, 32'h0,        0, 0, 0);
        tv[8]  = v(1, 32'h12, 0, 32'h0,   32'h0,        1, 1, 1, 32'hDEADBEEF, 0, 0, 0);
        tv[9]  = v(0, 32'h0,  1, 32'h200, 32'hFFFFFFFF, 0, 0, 1, 32'h0,        1, 0, 0);
        tv[10] = v(0, 32'h0,  1, 32'h200, 32'hFFFFFFFF, 0, 1, 0, 32'h0,        1, 0, 0);
        tv[11] = v(1, 32'h0,  0, 32'h0,   32'h0,        0, 0, 0, 32'h0,        1, 1, 1);
        tv[12] = v(1, 32'h0,  0, 32'h0,   32'h0,        1, 1, 0, 32'h0,        1, 0, 1);
        tv[13] = v(0, 32'h0,  0, 32'h0,   32'h0,        0, 0, 0, 32'h0,        1, 0, 1);
        tv[14] = v(1, 32'h4,  1, 32'h4,   32'h12345678, 0, 1, 1, 32'h11112222, 0, 0, 1);
        tv[15] = v(1, 32'h4,  0, 32'h0,   32'h0,        0, 0, 0, 32'h11112222, 0, 0, 1);
        tv[16] = v(1, 32'h4,  0, 32'h0,   32'h0,        1, 1, 0, 32'h11112222, 0, 1, 0);
        tv[17] = v(1, 32'h0,  0, 32'h0,   32'h0,        0, 0, 0, 32'h11112222, 0, 0, 0);
        tv[18] = v(1, 32'h0,  0, 32'h0,   32'h0,        1, 1, 1, 32'h12345678, 0, 0, 0);
        tv[19] = v(1, 32'h4,  0, 32'h0,   32'h0,        0, 0, 0, 32'h12345678, 0, 0, 0);
        tv[20] = v(1, 32'h4,  0, 32'h0,   32'h0,        1, 1, 1, 32'h11112222, 0, 0, 0);
        tv[21] = v(1, 32'h8,  0, 32'h0,   32'h0,        0, 0, 0, 32'h11112222, 0, 0, 0);
        tv[22] = v(1, 32'h8,  0, 32'h0,   32'h0,        1, 1, 1, 32'h12345678, 0, 0, 0);
        tv[23] = v(0, 32'h0,  0, 32'h0,   32'h0,        0, 0, 0, 32'h12345678, 0, 0, 0);
        tv[24] = v(0, 32'h0,  0, 32'h0,   32'h0,        1, 1, 1, 32'h33334444, 0, 0, 0);
        tv[25] = v(0, 32'h0,  0, 32'h0,   32'h0,        1, 1, 0, 32'h33334444, 0, 0, 0);

        rst = 1'b1;
        drive(1, 32'h0, 1, 32'h0, 64'h0);
        repeat (3) nxt();
        @(negedge clk);
        chk("rst_rd_ready", a_rr, 0);
        chk("rst_wr_ready", a_wr, 0);
        chk("rst_rsp", a_rsp, 0);
        chk("rst_rd_data", a_d, 0);
        chk("rst_rd_err", a_re, 0);
        chk("rst_wr_done", a_dn, 0);
        chk("rst_wr_err", a_we, 0);
        chk("rst_b_data", b_d, 0);
        nxt();
        rst = 1'b0;
        drive(0, 32'h0, 0, 32'h0, 64'h0);
        @(negedge clk);
        chk("post_rst_rd_ready", a_rr, 1);
        chk("post_rst_wr_ready", a_wr, 1);
        nxt();

        for (int i = 0; i < 26; i++) begin
            drive(tv[i].rv, tv[i].ra, tv[i].wv, tv[i].wa, {32'h0, tv[i].wd});
            @(negedge clk);
            chk($sformatf("v%0d_rd_ready", i), a_rr, tv[i].rr);
            chk($sformatf("v%0d_wr_ready", i), a_wr, tv[i].wr);
            chk($sformatf("v%0d_rsp", i), a_rsp, tv[i].rsp);
            chk($sformatf("v%0d_rd_data", i), a_d, tv[i].d);
            chk($sformatf("v%0d_rd_err", i), a_re, tv[i].re);
            chk($sformatf("v%0d_wr_done", i), a_dn, tv[i].dn);
            chk($sformatf("v%0d_wr_err", i), a_we, tv[i].we);
            nxt();
        end

        // reset in cycle 1 of a read aborts it
        drive(1, 32'h0, 0, 32'h0, 64'h0);
        @(negedge clk);
        chk("abort_accept", a_rr, 1);
        nxt();
        rst = 1'b1;
        drive(0, 32'h0, 0, 32'h0, 64'h0);
        @(negedge clk);
        chk("abort_rst_ready", a_rr, 0);
        chk("abort_rst_rsp", a_rsp, 0);
        nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_rsp_c2", a_rsp, 0);
        chk("abort_ready_c2", a_rr, 1);
        chk("abort_data_c2", a_d, 0);
        nxt();
        @(negedge clk);
        chk("abort_rsp_c3", a_rsp, 0);
        nxt();

        // 4-beat instance: write then read 0x0123456789ABCDEF at 0x8
        drive(0, 32'h0, 1, 32'h8, 64'h0123456789ABCDEF);
        @(negedge clk);
        chk("w64_accept", b_wr, 1);
        nxt();
        drive(0, 32'h0, 0, 32'h0, 64'h0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("w64_done_c%0d", k), b_dn, 0);
            chk($sformatf("w64_ready_c%0d", k), b_wr, 0);
            nxt();
        end
        drive(1, 32'h8, 0, 32'h0, 64'h0);
        @(negedge clk);
        chk("w64_done_c4", b_dn, 1);
        chk("w64_err_c4", b_we, 0);
        chk("r64_accept", b_rr, 1);
        nxt();
        drive(0, 32'h0, 0, 32'h0, 64'h0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("r64_rsp_c%0d", k), b_rsp, 0);
            nxt();
        end
        @(negedge clk);
        chk("r64_rsp_c4", b_rsp, 1);
        chk("r64_data", b_d, 64'h0123456789ABCDEF);
        chk("r64_err", b_re, 0);
        nxt();

        // 1-beat instance: single-cycle write, then reads every cycle
        drive(0, 32'h0, 1, 32'hC, 64'hCAFEF00D);
        @(negedge clk);
        chk("b1_wr_accept", c_wr, 1);
        nxt();
        drive(1, 32'hC, 0, 32'h0, 64'h0);
        @(negedge clk);
        chk("b1_done_c1", c_dn, 1);
        chk("b1_rd_ready_c1", c_rr, 1);
        nxt();
        @(negedge clk);
        chk("b1_rsp_c1", c_rsp, 1);
        chk("b1_data_c1", c_d, 32'hCAFEF00D);
        chk("b1_rd_ready_c2", c_rr, 1);
        nxt();
        drive(0, 32'h0, 0, 32'h0, 64'h0);
        @(negedge clk);
        chk("b1_rsp_c2", c_rsp, 1);
        chk("b1_data_c2", c_d, 32'hCAFEF00D);
        nxt();
        @(negedge clk);
        chk("b1_rsp_idle", c_rsp, 0);
        chk("b1_data_hold", c_d, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rv32i_instr_mem_banked.md
Name: rv32i_instr_mem_banked

Overview:
- Parametrised instruction memory that builds a DATA_W-bit word out of a narrower BRAM_W-bit synchronous block RAM.
- Each word is accessed over BEATS = DATA_W/BRAM_W consecutive BRAM cycles.
- Adds valid/ready request handshakes, single-cycle response strobes, address checking (misalignment, out-of-range) and a fixed write-over-read arbitration.
- Sits between the instruction-fetch unit (read side) and the boot loader/debug port (write side).

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of BRAM_W.
- BRAM_W, 16, native BRAM data width in bits; BEATS = DATA_W/BRAM_W must be a power of two, 1 or more.
- DEPTH_WORDS, 128, number of DATA_W words stored; power of two.
- ADDR_W, 32, byte-address width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_rd_valid  in  1  read request valid
- o_rd_ready  out  1  read request accepted when valid&&ready
- i_rd_addr  in  ADDR_W  read byte address
- o_rd_rsp_valid  out  1  one-cycle read response strobe
- o_rd_data  out  DATA_W  read data, held until next response
- o_rd_err  out  1  read error flag, qualified by o_rd_rsp_valid
- i_wr_valid  in  1  write request valid
- o_wr_ready  out  1  write request accepted when valid&&ready
- i_wr_addr  in  ADDR_W  write byte address
- i_wr_data  in  DATA_W  write data
- o_wr_done  out  1  one-cycle write completion strobe
- o_wr_err  out  1  write error flag, qualified by o_wr_done

Behaviour:
Reset
- While i_rst is high, every output is 0 (ready=0, strobes=0, o_rd_data=0, err=0). The FSM enters IDLE.
- Memory contents are not cleared and are undefined after power-up.
- Reset mid-operation aborts it. No response or done strobe is issued for the aborted request.
- A write aborted mid-way may leave the target word with mixed old and new beats.

FSM states: IDLE, RD, WR, ERR.
- Both o_rd_ready and o_wr_ready are high only in IDLE, and low in all other states.

Acceptance and arbitration (cycle 0 = acceptance edge)
- Arbitration: if both valids are high in IDLE, the write is accepted and o_rd_ready is driven low that cycle. The read stays pending.
- The address is captured at acceptance. Later changes to the request inputs are ignored.
- Address check: OFFS = log2(DATA_W/8).
  - Misaligned: i_*_addr[OFFS-1:0] != 0.
  - Out of range: word index addr[ADDR_W-1:OFFS] >= DEPTH_WORDS.
  - Either condition goes to ERR. There is no BRAM access.

Read
- Beat k (k = 0..BEATS-1) goes to BRAM address {word_idx, k} in cycle k.
- BRAM read latency is 1 cycle. Beat k is captured into slice [k*BRAM_W +: BRAM_W] (little-endian beat order).
- o_rd_data is registered. o_rd_rsp_valid pulses in cycle BEATS, with o_rd_err=0.
- The FSM is back in IDLE in cycle BEATS, so ready is high in the response cycle. A new request can be accepted then.
- Read throughput is one word per BEATS cycles.

Write
- Beat k, i_wr_data[k*BRAM_W +: BRAM_W], is written to {word_idx, k} in cycle k from the captured data.
- o_wr_done pulses in cycle BEATS, with o_wr_err=0. IDLE is re-entered in cycle BEATS.

ERR
- Lasts one cycle (cycle 1). The matching strobe pulses with err=1, and the FSM returns to IDLE.
- A read error drives o_rd_data to 0. A write error leaves memory unchanged.

BEATS=1 degenerate case
- Responses and done strobes arrive in cycle 1, so read throughput is 1 word per cycle.

Holding and ordering
- Strobes are never asserted together.
- o_rd_data/o_rd_err hold their value between read responses.
- No read-during-write hazard exists, because only one operation is ever in flight.

Test Plan:
1. Reset: hold i_rst 3 cycles with both valids high → all outputs 0 and no strobes; ready=1 in the first cycle after i_rst falls.
2. Write 0xDEADBEEF to 0x0000_0010, then read 0x10 (defaults) → o_wr_done in cycle 2, then o_rd_rsp_valid in cycle 2 after read accept with o_rd_data=0xDEADBEEF, err=0.
3. Read 0x0000_0012 (misaligned) and write 0x0000_0200 (word 128 ≥ DEPTH) → each returns its strobe in cycle 1 with err=1, o_rd_data=0; a later read of word 0 returns its prior contents.
4. Both valids high in the same IDLE cycle, write 0x12345678 @0x4, read @0x4 → write done first, then read returns 0x12345678.
5. Back-to-back reads @0x0,0x4,0x8 with valid held high → responses at cycles 2,4,6 with the correct data; ready low on odd cycles.
6. Assert i_rst in cycle 1 of a read → no o_rd_rsp_valid. With DATA_W=64, BRAM_W=16 (BEATS=4), write then read 0x0123456789ABCDEF → data matches, response in cycle 4.
